// File: rtl/imem_loadable_if.sv
// imem_loadable_if: fetch and program-load signal bundle for imem_loadable.
//   master : driven by the fetch stage / boot loader (requests, load stream)
//   slave  : the instruction memory (instruction, status, loader handshake)
// Fetch group : fetch_req, fetch_addr, fetch_stall -> instruction, fetch_valid, addr_fault
// Load group  : load_start, load_valid, load_data, load_last -> load_ready, load_done, load_count
// parity_err exists only when IMEM_PARITY_EN is defined.
interface imem_loadable_if #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int CW = 9
);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_stall;
    logic [DW-1:0] instruction;
    logic          fetch_valid;
    logic          addr_fault;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic [CW-1:0] load_count;
`ifdef IMEM_PARITY_EN
    logic          parity_err;

    modport master (
        output fetch_req, fetch_addr, fetch_stall,
        output load_start, load_valid, load_data, load_last,
        input  instruction, fetch_valid, addr_fault,
        input  load_ready, load_done, load_count, parity_err
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_stall,
        input  load_start, load_valid, load_data, load_last,
        output instruction, fetch_valid, addr_fault,
        output load_ready, load_done, load_count, parity_err
    );
`else
    modport master (
        output fetch_req, fetch_addr, fetch_stall,
        output load_start, load_valid, load_data, load_last,
        input  instruction, fetch_valid, addr_fault,
        input  load_ready, load_done, load_count
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_stall,
        input  load_start, load_valid, load_data, load_last,
        output instruction, fetch_valid, addr_fault,
        output load_ready, load_done, load_count
    );
`endif
endinterface

// File: rtl/imem_loadable.sv
// imem_loadable: synchronous instruction memory with a registered fetch port
// and a streaming program-load port driven by a two-state loader FSM.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - imem_loadable_if.slave (fetch request/response, load stream, status)
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit with
// every word, recheck it on fetch and report mismatches on bus.parity_err.
//
// state | meaning
// IDLE  | fetches serviced, waiting for load_start
// LOAD  | accepting load words, fetches dropped
module imem_loadable #(
    parameter int          DW    = 8,
    parameter int          AW    = 8,
    parameter int          DEPTH = 256,
    parameter logic [DW-1:0] NOP = '0,
    parameter int          CW    = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst,
    imem_loadable_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] count_q;
    logic          ready_q;
    logic          done_q;
    logic [DW-1:0] instr_q;
    logic          valid_q;
    logic          fault_q;
    logic          perr_q;

    logic [MW-1:0] mem_q [DEPTH];

    logic          wr_en;
    logic          last_wr;
    logic [MW-1:0] wr_word;
    logic          fetch_acc;
    logic          in_range;
    logic [MW-1:0] rd_word;
    logic          rd_bad;

    assign wr_en   = (state_q == LOAD) && bus.load_valid;
    // The session also ends on the top word so the pointer never wraps.
    assign last_wr = wr_en && (bus.load_last || (ptr_q == PW'(DEPTH - 1)));

`ifdef IMEM_PARITY_EN
    assign wr_word = {^bus.load_data, bus.load_data};
    // Stored word carries even parity, so any set XOR means corruption.
    assign rd_bad  = ^rd_word;
`else
    assign wr_word = bus.load_data;
    assign rd_bad  = 1'b0;
`endif

    // The cycle load_start is sampled is still IDLE, so that fetch is served.
    assign fetch_acc = bus.fetch_req && (state_q == IDLE);
    // One extra bit so DEPTH == 2**AW compares correctly.
    assign in_range  = ({1'b0, bus.fetch_addr} < (AW + 1)'(DEPTH));
    assign rd_word   = mem_q[bus.fetch_addr[PW-1:0]];

    // No reset on the array: a reset mid-load keeps already written words.
    // Non-blocking write gives read-before-write on a same-cycle fetch.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_start) begin
                        state_q <= LOAD;
                        ptr_q   <= '0;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        ptr_q   <= ptr_q + PW'(1);
                        count_q <= count_q + CW'(1);
                    end
                    if (last_wr) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (bus.fetch_stall) begin
                instr_q <= instr_q;
            end else if (fetch_acc) begin
                valid_q <= 1'b1;
                if (!in_range) begin
                    instr_q <= NOP;
                    fault_q <= 1'b1;
                    perr_q  <= 1'b0;
                end else if (rd_bad) begin
                    instr_q <= NOP;
                    fault_q <= 1'b0;
                    perr_q  <= 1'b1;
                end else begin
                    instr_q <= rd_word[DW-1:0];
                    fault_q <= 1'b0;
                    perr_q  <= 1'b0;
                end
            end else begin
                valid_q <= 1'b0;
                fault_q <= 1'b0;
                perr_q  <= 1'b0;
            end
        end
    end

    assign bus.instruction = instr_q;
    assign bus.fetch_valid = valid_q;
    assign bus.addr_fault  = fault_q;
    assign bus.load_ready  = ready_q;
    assign bus.load_done   = done_q;
    assign bus.load_count  = count_q;
`ifdef IMEM_PARITY_EN
    assign bus.parity_err  = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q;
`endif
endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    logic [7:0] prog [5];

    imem_loadable_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    imem_loadable #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .NOP(8'h00), .CW(CW)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        prog[0] = 8'h41; prog[1] = 8'h00; prog[2] = 8'h69; prog[3] = 8'hB1; prog[4] = 8'hC2;

        rst = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.fetch_stall = 1'b0;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_instr", 32'(bus.instruction), 32'h00);
        check("rst_valid", 32'(bus.fetch_valid), 0);
        check("rst_fault", 32'(bus.addr_fault), 0);
        check("rst_ready", 32'(bus.load_ready), 0);
        check("rst_done", 32'(bus.load_done), 0);
        check("rst_count", 32'(bus.load_count), 0);
`ifdef IMEM_PARITY_EN
        check("rst_perr", 32'(bus.parity_err), 0);
`endif
        step();
        check("idle_valid", 32'(bus.fetch_valid), 0);

        // five-word program load
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("ld_ready", 32'(bus.load_ready), 1);
        check("ld_count0", 32'(bus.load_count), 0);
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            bus.load_last  = (i == 4);
            step();
            check("ld_count", 32'(bus.load_count), 32'(i + 1));
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("ld_done", 32'(bus.load_done), 1);
        check("ld_ready_off", 32'(bus.load_ready), 0);

        // pipelined fetches 0..4
        for (int i = 0; i < 5; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 8'(i);
            step();
            check("fetch_instr", 32'(bus.instruction), 32'(prog[i]));
            check("fetch_valid", 32'(bus.fetch_valid), 1);
        end
        bus.fetch_req = 1'b0;
        step();
        check("noreq_valid", 32'(bus.fetch_valid), 0);
        check("noreq_hold", 32'(bus.instruction), 32'hC2);

        // stall holds outputs
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd2;
        step();
        check("stall_pre", 32'(bus.instruction), 32'h69);
        bus.fetch_addr  = 8'd3;
        bus.fetch_stall = 1'b1;
        repeat (3) begin
            step();
            check("stall_instr", 32'(bus.instruction), 32'h69);
            check("stall_valid", 32'(bus.fetch_valid), 1);
        end
        bus.fetch_stall = 1'b0;
        step();
        check("stall_rel", 32'(bus.instruction), 32'hB1);

        // out-of-range fetches
        bus.fetch_addr = 8'd4;
        step();
        check("pre_fault", 32'(bus.instruction), 32'hC2);
        bus.fetch_addr = 8'h20;
        step();
        check("fault_instr", 32'(bus.instruction), 32'h00);
        check("fault_flag", 32'(bus.addr_fault), 1);
        check("fault_valid", 32'(bus.fetch_valid), 1);
        bus.fetch_addr = 8'd16;
        step();
        check("fault_depth", 32'(bus.addr_fault), 1);
        bus.fetch_addr = 8'd4;
        step();
        check("fault_clr", 32'(bus.addr_fault), 0);
        check("fault_clr_instr", 32'(bus.instruction), 32'hC2);
        bus.fetch_addr = 8'h20;
        step();
        bus.fetch_addr  = 8'd0;
        bus.fetch_stall = 1'b1;
        step();
        check("fault_stall", 32'(bus.addr_fault), 1);
        bus.fetch_stall = 1'b0;
        bus.fetch_req   = 1'b0;
        step();
        check("fault_noreq", 32'(bus.addr_fault), 0);
        check("fault_noreq_v", 32'(bus.fetch_valid), 0);

        // load/fetch overlap
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd0;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("ovl_old", 32'(bus.instruction), 32'h41);
        check("ovl_valid", 32'(bus.fetch_valid), 1);
        check("ovl_done_clr", 32'(bus.load_done), 0);
        check("ovl_count_clr", 32'(bus.load_count), 0);
        step();
        check("ovl_drop", 32'(bus.fetch_valid), 0);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h7E;
        bus.load_last  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("ovl_drop2", 32'(bus.fetch_valid), 0);
        check("ovl_done", 32'(bus.load_done), 1);
        check("ovl_count", 32'(bus.load_count), 1);
        step();
        check("ovl_new", 32'(bus.instruction), 32'h7E);
        check("ovl_new_v", 32'(bus.fetch_valid), 1);
        bus.fetch_addr = 8'd1;
        step();
        check("ovl_untouched", 32'(bus.instruction), 32'h00);
        bus.fetch_req = 1'b0;

        // full-depth load ends on the top word, with a gap and an ignored load_start
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 6) begin
                bus.load_valid = 1'b0;
                step();
                check("full_gap", 32'(bus.load_count), 6);
            end
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(8'h10 + i);
            bus.load_start = (i == 9);
            step();
            if (i == DEPTH - 2) check("full_not_done", 32'(bus.load_done), 0);
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
        check("full_done", 32'(bus.load_done), 1);
        check("full_count", 32'(bus.load_count), 16);
        check("full_ready", 32'(bus.load_ready), 0);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd15;
        step();
        check("full_top", 32'(bus.instruction), 32'h1F);
        bus.fetch_addr = 8'd0;
        step();
        check("full_bot", 32'(bus.instruction), 32'h10);
        bus.fetch_req = 1'b0;

        // reset mid-load
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(8'hA0 + i);
            step();
        end
        bus.load_valid = 1'b0;
        check("mid_count", 32'(bus.load_count), 3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus.load_count), 0);
        check("mid_rst_done", 32'(bus.load_done), 0);
        check("mid_rst_ready", 32'(bus.load_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd1;
        step();
        check("mid_kept", 32'(bus.instruction), 32'hA1);
        check("mid_idle", 32'(bus.fetch_valid), 1);
        bus.fetch_addr = 8'd3;
        step();
        check("mid_old", 32'(bus.instruction), 32'h13);

`ifdef IMEM_PARITY_EN
        u_dut.mem_q[1][0] = ~u_dut.mem_q[1][0];
        bus.fetch_addr = 8'd1;
        step();
        check("par_instr", 32'(bus.instruction), 32'h00);
        check("par_err", 32'(bus.parity_err), 1);
        check("par_valid", 32'(bus.fetch_valid), 1);
        bus.fetch_addr = 8'd2;
        step();
        check("par_clr", 32'(bus.parity_err), 0);
        check("par_good", 32'(bus.instruction), 32'hA2);
`endif
        bus.fetch_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
